// File: rtl/sprite_finder_scheduler_pkg.sv
// Shared types and constants for the sprite finder scheduler:
// command packing, selector codes and FSM state encoding.
package sprite_sched_pkg;

    localparam int CMD_W    = 40;
    localparam int SEL_LSB  = 38;
    localparam int SEL_W    = 2;
    localparam int ID_LSB   = 32;
    localparam int ID_W     = 6;
    localparam int COL_LSB  = 22;
    localparam int COL_W    = 10;
    localparam int ROW_LSB  = 12;
    localparam int ROW_W    = 10;
    localparam int IN01_LSB = 6;
    localparam int IN01_W   = 6;
    localparam int IN02_LSB = 0;
    localparam int IN02_W   = 6;

    localparam logic [ID_W-1:0] NO_SPRITE_ID = 6'h3F;

    typedef enum logic [1:0] {
        SEL_LEVEL    = 2'b00,
        SEL_POS      = 2'b01,
        SEL_COLISION = 2'b10,
        SEL_INVALID  = 2'b11
    } sel_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_POS_GO    = 3'd1,
        ST_POS_WAIT  = 3'd2,
        ST_FUNC_GO   = 3'd3,
        ST_FUNC_WAIT = 3'd4
    } state_t;

    function automatic sel_t cmd_sel(input logic [CMD_W-1:0] cmd);
        return sel_t'(cmd[SEL_LSB +: SEL_W]);
    endfunction

endpackage

// File: rtl/sprite_finder_scheduler_if.sv
// Requester-side (VGA pixel path, CPU command path) and finder-side signals
// of the scheduler; slave is the scheduler's view, master the environment's.
interface sprite_finder_scheduler_if;
    import sprite_sched_pkg::*;

    logic             blank;
    logic             pix_req;
    logic             pix_ready;
    logic [9:0]       pix_h;
    logic [9:0]       pix_v;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CMD_W-1:0] cmd_data;
    logic             err_clr;
    logic             fp_pos_go;
    logic [9:0]       fp_h;
    logic [9:0]       fp_v;
    logic             fp_func_go;
    logic [CMD_W-1:0] fp_cmd;
    logic             fp_high_four;
    logic             fp_colision;
    logic             pix_done;
    logic             cmd_done;
    logic             colision_hit;
    logic             timeout_err;

    modport slave (
        input  blank, pix_req, pix_h, pix_v, cmd_valid, cmd_data, err_clr,
               fp_high_four, fp_colision,
        output pix_ready, cmd_ready, fp_pos_go, fp_h, fp_v, fp_func_go, fp_cmd,
               pix_done, cmd_done, colision_hit, timeout_err
    );

    modport master (
        output blank, pix_req, pix_h, pix_v, cmd_valid, cmd_data, err_clr,
               fp_high_four, fp_colision,
        input  pix_ready, cmd_ready, fp_pos_go, fp_h, fp_v, fp_func_go, fp_cmd,
               pix_done, cmd_done, colision_hit, timeout_err
    );

endinterface

// File: rtl/sprite_cmd_fifo.sv
// CPU command FIFO; pointers carry a wrap bit so full/empty need no counter.
module sprite_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    // when full, a same-cycle pop frees the very slot the push lands in
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sprite_finder_scheduler.sv
// Shares the sprite finder between VGA pixel lookups and queued CPU functions.
// state      | meaning
// IDLE       | arbitrate: queued command (blank or starved) before pixel
// POS_GO     | fp_pos_go pulse with latched fp_h/fp_v
// POS_WAIT   | wait for fp_high_four or POS_TMO timeout
// FUNC_GO    | fp_func_go pulse, or drop an invalid selector
// FUNC_WAIT  | fixed FUNC_LAT window, collision OR-accumulated
module sprite_finder_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int CMD_DEPTH  = 4,
    parameter int FUNC_LAT   = 4,
    parameter int POS_TMO    = 64,
    parameter int STARVE_MAX = 800
) (
    input logic                      clk,
    input logic                      rst,
    sprite_finder_scheduler_if.slave bus
);
    localparam int TMR_MAX = (POS_TMO > FUNC_LAT) ? POS_TMO : FUNC_LAT;
    localparam int TW      = $clog2(TMR_MAX) + 1;
    localparam int SW      = $clog2(STARVE_MAX + 1);

    state_t           state;
    state_t           state_nxt;
    logic [TW-1:0]    tmr;
    logic [SW-1:0]    starve_cnt;
    logic             col_acc;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [CMD_W-1:0] fifo_head;
    logic             issue_cmd;
    logic             grant_pix;
    logic             tmr_zero;
    logic             pos_exit;
    logic             func_exit;

    sprite_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.cmd_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign issue_cmd = (state == ST_IDLE) && !fifo_empty &&
                       (bus.blank || (starve_cnt == SW'(STARVE_MAX)));
    assign grant_pix = (state == ST_IDLE) && !issue_cmd && bus.pix_req;
    assign fifo_pop  = issue_cmd;
    assign bus.cmd_ready = !fifo_full || fifo_pop;
    assign fifo_push = bus.cmd_valid && bus.cmd_ready;
    assign tmr_zero  = (tmr == '0);
    assign pos_exit  = (state == ST_POS_WAIT) && (bus.fp_high_four || tmr_zero);
    assign func_exit = (state == ST_FUNC_WAIT) && tmr_zero;

    always_comb begin
        state_nxt      = state;
        bus.pix_ready  = 1'b0;
        bus.fp_pos_go  = 1'b0;
        bus.fp_func_go = 1'b0;
        bus.pix_done   = 1'b0;
        bus.cmd_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.pix_ready = !issue_cmd;
                if (issue_cmd)        state_nxt = ST_FUNC_GO;
                else if (bus.pix_req) state_nxt = ST_POS_GO;
            end
            ST_POS_GO: begin
                bus.fp_pos_go = 1'b1;
                state_nxt     = ST_POS_WAIT;
            end
            ST_POS_WAIT: begin
                if (pos_exit) begin
                    bus.pix_done = 1'b1;
                    state_nxt    = ST_IDLE;
                end
            end
            ST_FUNC_GO: begin
                if (cmd_sel(bus.fp_cmd) == SEL_INVALID) begin
                    bus.cmd_done = 1'b1;
                    state_nxt    = ST_IDLE;
                end else begin
                    bus.fp_func_go = 1'b1;
                    state_nxt      = ST_FUNC_WAIT;
                end
            end
            ST_FUNC_WAIT: begin
                if (func_exit) begin
                    bus.cmd_done = 1'b1;
                    state_nxt    = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            tmr              <= '0;
            starve_cnt       <= '0;
            col_acc          <= 1'b0;
            bus.fp_h         <= '0;
            bus.fp_v         <= '0;
            bus.fp_cmd       <= '0;
            bus.colision_hit <= 1'b0;
            bus.timeout_err  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (grant_pix) begin
                bus.fp_h <= bus.pix_h;
                bus.fp_v <= bus.pix_v;
            end

            if (issue_cmd) begin
                bus.fp_cmd <= fifo_head;
                starve_cnt <= '0;
            end else if (grant_pix && !fifo_empty && !bus.blank &&
                         (starve_cnt != SW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            // one down-counter serves both the lookup timeout and the function window
            case (state)
                ST_POS_GO:                tmr <= TW'(POS_TMO - 1);
                ST_FUNC_GO:               tmr <= TW'(FUNC_LAT - 1);
                ST_POS_WAIT, ST_FUNC_WAIT: if (!tmr_zero) tmr <= tmr - 1'b1;
                default:                  tmr <= tmr;
            endcase

            if (state == ST_FUNC_GO)        col_acc <= 1'b0;
            else if (state == ST_FUNC_WAIT) col_acc <= col_acc | bus.fp_colision;

            if (func_exit && (cmd_sel(bus.fp_cmd) == SEL_COLISION))
                bus.colision_hit <= col_acc | bus.fp_colision;

            if (pos_exit && !bus.fp_high_four) bus.timeout_err <= 1'b1;
            else if (bus.err_clr)              bus.timeout_err <= 1'b0;
        end
    end

endmodule
